// File: rtl/base_const_pkg.sv
// Shared definitions for the programmable constant bank: FSM state
// encoding, an index-width helper and a channel slice extractor.
package base_const_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_APPLY = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Widest packed constant vector the slice helper accepts (64 x 64 bits).
    localparam int VEC_MAX_W = 4096;

    // Ceiling log2, used to size a channel index from a channel count.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Extract channel idx (w bits wide, little-end packing) from a packed vector.
    function automatic logic [63:0] chan_slice(input logic [VEC_MAX_W-1:0] vec,
                                               input int idx, input int w);
        logic [VEC_MAX_W-1:0] shifted;
        logic [63:0]          mask;
        shifted = vec >> (idx * w);
        mask    = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        return shifted[63:0] & mask;
    endfunction

endpackage

// File: rtl/base_const_chan.sv
// One channel of the constant bank: a shadow register written by software
// and an active register that only follows the shadow on an apply strobe.
module base_const_chan
    import base_const_pkg::*;
#(
    parameter int               width     = 32,
    parameter logic [width-1:0] rst_value = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [width-1:0] wr_data,
    input  logic             apply_en,
    output logic [width-1:0] active
);

    logic [width-1:0] shadow_r;
    logic [width-1:0] active_r;

    // Shadow copy: loads the reset constant, then tracks accepted writes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shadow_r <= rst_value;
        end else if (wr_en) begin
            shadow_r <= wr_data;
        end
    end

    // Active copy: changes only on reset or on the bank-wide apply strobe.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            active_r <= rst_value;
        end else if (apply_en) begin
            active_r <= shadow_r;
        end
    end

    assign active = active_r;

endmodule

// File: rtl/base_const_bank.sv
// Bank of run-time programmable constants with shadow writes and an atomic
// commit (IDLE -> APPLY -> DONE). Optional lock via BASE_CONST_BANK_LOCK_EN:
// once locked, writes are swallowed and commits ignored until reset.
module base_const_bank
    import base_const_pkg::*;
#(
    parameter int                        width    = 32,
    parameter int                        channels = 4,
    parameter int                        chan_w   = 2,
    parameter logic [channels*width-1:0] value    = '0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      i_wr_v,
    output logic                      i_wr_r,
    input  logic [chan_w-1:0]         i_wr_chan,
    input  logic [width-1:0]          i_wr_data,
    input  logic                      i_commit,
    output logic                      o_commit_ack,
    output logic                      o_pend,
    output logic                      o_err,
    input  logic                      i_lock,
    output logic                      o_locked,
    output logic [channels*width-1:0] dout
);

    localparam logic [chan_w:0] chan_lim_c = (chan_w + 1)'(channels);

    logic [1:0] state_r;
    logic [1:0] state_nx_s;
    logic       wr_r_r;
    logic       ack_r;
    logic       pend_r;
    logic       err_r;
    logic       locked_s;
    logic       locked_nx_s;
    logic       wr_acc_s;
    logic       in_range_s;
    logic       wr_en_s;
    logic       apply_s;

`ifdef BASE_CONST_BANK_LOCK_EN
    logic locked_r;

    // Lock is sticky: any i_lock pulse holds until reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            locked_r <= 1'b0;
        end else if (i_lock) begin
            locked_r <= 1'b1;
        end
    end

    assign locked_s    = locked_r;
    assign locked_nx_s = locked_r | i_lock;
`else
    logic unused_lock_s;
    assign unused_lock_s = i_lock;
    assign locked_s      = 1'b0;
    assign locked_nx_s   = 1'b0;
`endif

    assign wr_acc_s   = i_wr_v & wr_r_r;
    assign in_range_s = ({1'b0, i_wr_chan} < chan_lim_c);
    assign wr_en_s    = wr_acc_s & in_range_s & ~locked_s;
    assign apply_s    = (state_r == ST_APPLY);

    // Commit sequencing; a commit is only taken from IDLE and never while locked.
    always_comb begin
        state_nx_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (i_commit && !locked_s) begin
                    state_nx_s = ST_APPLY;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_APPLY: state_nx_s = ST_DONE;
            ST_DONE:  state_nx_s = ST_IDLE;
            default:  state_nx_s = ST_IDLE;
        endcase
    end

    // Control registers: state, registered ready/ack, pending and error flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            wr_r_r  <= 1'b1;
            ack_r   <= 1'b0;
            pend_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            // Writes stall only during APPLY so the copy sees a stable shadow.
            wr_r_r  <= locked_nx_s | (state_nx_s != ST_APPLY);
            ack_r   <= apply_s;
            // A write landing in DONE re-arms pending after the APPLY clear.
            if (wr_en_s) begin
                pend_r <= 1'b1;
            end else if (apply_s) begin
                pend_r <= 1'b0;
            end
            if (wr_acc_s && !in_range_s && !locked_s) begin
                err_r <= 1'b1;
            end
        end
    end

    genvar c;
    generate
        for (c = 0; c < channels; c++) begin : g_chan
            localparam logic [width-1:0] rst_c =
                width'(chan_slice(VEC_MAX_W'(value), c, width));

            base_const_chan #(
                .width     (width),
                .rst_value (rst_c)
            ) u_chan (
                .clk      (clk),
                .reset_n  (reset_n),
                .wr_en    (wr_en_s && (i_wr_chan == chan_w'(c))),
                .wr_data  (i_wr_data),
                .apply_en (apply_s),
                .active   (dout[c*width +: width])
            );
        end
    endgenerate

    assign i_wr_r       = wr_r_r;
    assign o_commit_ack = ack_r;
    assign o_pend       = pend_r;
    assign o_err        = err_r;
    assign o_locked     = locked_s;

endmodule

// File: tb/tb_base_const_bank.sv
// Directed self-checking bench for base_const_bank (width=8, channels=4,
// chan_w=3). Lock expectations follow BASE_CONST_BANK_LOCK_EN.
module tb_base_const_bank;

    logic        clk;
    logic        reset_n;
    logic        i_wr_v;
    logic        i_wr_r;
    logic [2:0]  i_wr_chan;
    logic [7:0]  i_wr_data;
    logic        i_commit;
    logic        o_commit_ack;
    logic        o_pend;
    logic        o_err;
    logic        i_lock;
    logic        o_locked;
    logic [31:0] dout;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    base_const_bank #(
        .width    (8),
        .channels (4),
        .chan_w   (3),
        .value    (32'h44332211)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_wr_v       (i_wr_v),
        .i_wr_r       (i_wr_r),
        .i_wr_chan    (i_wr_chan),
        .i_wr_data    (i_wr_data),
        .i_commit     (i_commit),
        .o_commit_ack (o_commit_ack),
        .o_pend       (o_pend),
        .o_err        (o_err),
        .i_lock       (i_lock),
        .o_locked     (o_locked),
        .dout         (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            fail_cnt = fail_cnt + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; i_wr_v = 1'b0; i_wr_chan = 3'd0; i_wr_data = 8'h00;
        i_commit = 1'b0; i_lock = 1'b0;
        tick(); tick();
        // Reset state
        check("rst_dout", dout, 32'h44332211);
        check("rst_wr_r", {31'd0, i_wr_r}, 32'd1);
        check("rst_pend", {31'd0, o_pend}, 32'd0);
        check("rst_err",  {31'd0, o_err}, 32'd0);
        check("rst_ack",  {31'd0, o_commit_ack}, 32'd0);
        check("rst_lock", {31'd0, o_locked}, 32'd0);
        reset_n = 1'b1;
        tick();
        check("idle_wr_r", {31'd0, i_wr_r}, 32'd1);

        // Two writes to ch2, last wins, then commit
        i_wr_v = 1'b1; i_wr_chan = 3'd2; i_wr_data = 8'hAA;
        tick();
        check("pend_after_wr", {31'd0, o_pend}, 32'd1);
        i_wr_data = 8'hBB;
        tick();
        i_wr_v = 1'b0; i_commit = 1'b1;
        tick();
        i_commit = 1'b0;
        check("t1_dout", dout, 32'h44332211);
        check("t1_ack",  {31'd0, o_commit_ack}, 32'd0);
        check("t1_wr_r", {31'd0, i_wr_r}, 32'd0);
        tick();
        check("t2_dout", dout, 32'h44BB2211);
        check("t2_ack",  {31'd0, o_commit_ack}, 32'd1);
        check("t2_pend", {31'd0, o_pend}, 32'd0);
        tick();
        check("ack_pulse_end", {31'd0, o_commit_ack}, 32'd0);

        // Write concurrent with commit, then a write held through APPLY
        i_wr_v = 1'b1; i_wr_chan = 3'd0; i_wr_data = 8'h5A; i_commit = 1'b1;
        tick();
        i_commit = 1'b0; i_wr_chan = 3'd1; i_wr_data = 8'h77;
        check("apply_wr_r", {31'd0, i_wr_r}, 32'd0);
        check("apply_dout", dout, 32'h44BB2211);
        tick();
        check("co_dout", dout, 32'h44BB225A);
        check("co_ack",  {31'd0, o_commit_ack}, 32'd1);
        check("done_wr_r", {31'd0, i_wr_r}, 32'd1);
        tick();
        i_wr_v = 1'b0;
        check("done_wr_pend", {31'd0, o_pend}, 32'd1);
        check("done_wr_dout", dout, 32'h44BB225A);

        // Flush ch1=77 so pending is clear before the range test
        i_commit = 1'b1;
        tick();
        i_commit = 1'b0;
        tick();
        tick();
        check("flush_dout", dout, 32'h44BB775A);
        check("flush_pend", {31'd0, o_pend}, 32'd0);

        // Out-of-range channel index
        check("oor_ready", {31'd0, i_wr_r}, 32'd1);
        i_wr_v = 1'b1; i_wr_chan = 3'd5; i_wr_data = 8'hEE;
        tick();
        i_wr_v = 1'b0;
        check("oor_err",  {31'd0, o_err}, 32'd1);
        check("oor_pend", {31'd0, o_pend}, 32'd0);
        check("oor_dout", dout, 32'h44BB775A);
        tick(); tick();
        check("oor_sticky", {31'd0, o_err}, 32'd1);

        // Reset in the middle of APPLY
        i_wr_v = 1'b1; i_wr_chan = 3'd1; i_wr_data = 8'hCC;
        tick();
        i_wr_v = 1'b0; i_commit = 1'b1;
        tick();
        i_commit = 1'b0; reset_n = 1'b0;
        tick();
        check("mid_rst_dout", dout, 32'h44332211);
        check("mid_rst_ack",  {31'd0, o_commit_ack}, 32'd0);
        check("mid_rst_err",  {31'd0, o_err}, 32'd0);
        reset_n = 1'b1;
        tick();
        check("post_rst_ack",  {31'd0, o_commit_ack}, 32'd0);
        check("post_rst_wr_r", {31'd0, i_wr_r}, 32'd1);
        check("post_rst_dout", dout, 32'h44332211);

        // Lock, then write ch3=00 and commit
        i_lock = 1'b1;
        tick();
        i_lock = 1'b0;
        i_wr_v = 1'b1; i_wr_chan = 3'd3; i_wr_data = 8'h00;
        tick();
        i_wr_v = 1'b0; i_commit = 1'b1;
`ifdef BASE_CONST_BANK_LOCK_EN
        check("lk_locked", {31'd0, o_locked}, 32'd1);
        check("lk_pend",   {31'd0, o_pend}, 32'd0);
`else
        check("lk_locked", {31'd0, o_locked}, 32'd0);
        check("lk_pend",   {31'd0, o_pend}, 32'd1);
`endif
        tick();
        i_commit = 1'b0;
        tick();
`ifdef BASE_CONST_BANK_LOCK_EN
        check("lk_ack",  {31'd0, o_commit_ack}, 32'd0);
        check("lk_dout", dout, 32'h44332211);
`else
        check("lk_ack",  {31'd0, o_commit_ack}, 32'd1);
        check("lk_dout", dout, 32'h00332211);
`endif
        check("lk_pend_end", {31'd0, o_pend}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
